// File: rtl/gpu_wb_master_if.sv
// Command, Wishbone and response signals of gpu_wb_master, grouped in one bundle.
// master = the initiator's view; slave = the command source / GPU / response sink view.
interface gpu_wb_master_if;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic        i_cmd_we;
  logic [26:0] i_cmd_adr;
  logic [31:0] i_cmd_dat;
  logic [3:0]  i_cmd_sel;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [26:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_data;
  logic        o_rsp_err;
  logic        o_busy;

  modport master (
    input  i_cmd_valid, i_cmd_we, i_cmd_adr, i_cmd_dat, i_cmd_sel, wb_dat_i, wb_ack_i,
    output o_cmd_ready, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
           o_rsp_valid, o_rsp_data, o_rsp_err, o_busy
  );

  modport slave (
    output i_cmd_valid, i_cmd_we, i_cmd_adr, i_cmd_dat, i_cmd_sel, wb_dat_i, wb_ack_i,
    input  o_cmd_ready, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
           o_rsp_valid, o_rsp_data, o_rsp_err, o_busy
  );
endinterface

// File: rtl/gpu_wb_master.sv
// Wishbone classic single-transfer initiator with a command FIFO feeding the GPU slave port.
// Optional ack timeout enabled by defining GPU_WB_TIMEOUT_EN.
module gpu_wb_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 255
) (
  input logic             clk,
  input logic             reset,
  gpu_wb_master_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("gpu_wb_master: FIFO_DEPTH must be a power of two >= 2");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("gpu_wb_master: GAP_CYCLES must be >= 1");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("gpu_wb_master: TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t          state_q, state_d;
  logic [63:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic            cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [3:0]      sel_q, sel_d;
  logic [26:0]     adr_q, adr_d;
  logic [31:0]     dat_q, dat_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic            busy_q, busy_d;
  logic            full, push, pop;
  logic [63:0]     head;
`ifdef GPU_WB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic            rsp_err_q, rsp_err_d;
`endif

  // Ready comes from the registered count, so a pop in the same cycle cannot open a slot.
  assign full = (count_q == CW'(FIFO_DEPTH));
  assign push = bus.i_cmd_valid & ~full;
  assign head = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.i_cmd_we, bus.i_cmd_sel, bus.i_cmd_adr, bus.i_cmd_dat};
  end

  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    pop         = 1'b0;
`ifdef GPU_WB_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop                        = 1'b1;
          {we_d, sel_d, adr_d, dat_d} = head;
          cyc_d                      = 1'b1;
          stb_d                      = 1'b1;
          state_d                    = REQ;
`ifdef GPU_WB_TIMEOUT_EN
          tmo_cnt_d                  = '0;
`endif
        end
      end
      REQ: begin
        if (bus.wb_ack_i) begin
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          we_d      = 1'b0;
          gap_cnt_d = '0;
          state_d   = GAP;
          if (!we_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = bus.wb_dat_i;
`ifdef GPU_WB_TIMEOUT_EN
            rsp_err_d   = 1'b0;
`endif
          end
`ifdef GPU_WB_TIMEOUT_EN
        end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          we_d        = 1'b0;
          gap_cnt_d   = '0;
          state_d     = GAP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
`endif
        end
      end
      GAP: begin
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    busy_d   = (count_d != '0) | (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      gap_cnt_q   <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
`ifdef GPU_WB_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      gap_cnt_q   <= gap_cnt_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
`ifdef GPU_WB_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign bus.o_cmd_ready = ~full;
  assign bus.wb_cyc_o    = cyc_q;
  assign bus.wb_stb_o    = stb_q;
  assign bus.wb_we_o     = we_q;
  assign bus.wb_sel_o    = sel_q;
  assign bus.wb_adr_o    = adr_q;
  assign bus.wb_dat_o    = dat_q;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_data  = rsp_data_q;
  assign bus.o_busy      = busy_q;
`ifdef GPU_WB_TIMEOUT_EN
  assign bus.o_rsp_err   = rsp_err_q;
`else
  assign bus.o_rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_gpu_wb_master.sv
// Directed bench for gpu_wb_master: writes, reads, FIFO full, half-rate slave, reset, timeout.
// A configurable slave model answers the bus; a negedge monitor records what the bus did.
module tb_gpu_wb_master;
  logic clk;
  logic reset;
  gpu_wb_master_if bus();

  gpu_wb_master #(.FIFO_DEPTH(4), .GAP_CYCLES(1), .TIMEOUT(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Slave: 0 = never ack, 1 = single ack once lat cycles of REQ have passed, 2 = half-rate registered ack
  int          slave_mode = 0;
  int          lat = 0;
  int          lat_cnt = 0;
  logic        ack_nxt = 1'b0;

  int          ack_cnt = 0, stb_cnt = 0, rsp_cnt = 0;
  int          cur_len = 0, last_len = 0, idle_run = 0, min_gap = 1000;
  logic        prev_stb = 1'b0;
  logic [31:0] last_rsp_data = '0;
  logic        last_rsp_err = 1'b0;
  logic [26:0] iss_q[$];

  always @(negedge clk) begin
    if (bus.wb_cyc_o && bus.wb_stb_o && !reset) begin
      case (slave_mode)
        1:       ack_nxt = (lat_cnt >= lat) && !bus.wb_ack_i;
        2:       ack_nxt = 1'b1;
        default: ack_nxt = 1'b0;
      endcase
      lat_cnt++;
      if (bus.wb_ack_i) ack_cnt++;
    end else begin
      ack_nxt = 1'b0;
      lat_cnt = 0;
    end
    if (bus.wb_cyc_o) cur_len++;
    else if (cur_len != 0) begin
      last_len = cur_len;
      cur_len  = 0;
    end
    if (bus.wb_stb_o && !prev_stb) begin
      stb_cnt++;
      iss_q.push_back(bus.wb_adr_o);
      if (idle_run < min_gap) min_gap = idle_run;
    end
    if (!bus.wb_stb_o) idle_run++;
    else idle_run = 0;
    prev_stb = bus.wb_stb_o;
    if (bus.o_rsp_valid) begin
      rsp_cnt++;
      last_rsp_data = bus.o_rsp_data;
      last_rsp_err  = bus.o_rsp_err;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) bus.wb_ack_i <= 1'b0;
    else       bus.wb_ack_i <= ack_nxt;
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic we, input logic [26:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    int n;
    bus.i_cmd_we    = we;
    bus.i_cmd_adr   = adr;
    bus.i_cmd_dat   = dat;
    bus.i_cmd_sel   = sel;
    bus.i_cmd_valid = 1'b1;
    n = 0;
    while (!bus.o_cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("push_ready_wait", {63'd0, bus.o_cmd_ready}, 64'd1);
    tick();
    bus.i_cmd_valid = 1'b0;
    $display("push we=%0d adr=%07h dat=%08h sel=%0h", we, adr, dat, sel);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.o_busy && n < 200) begin
      tick();
      n++;
    end
    chk(tag, {63'd0, bus.o_busy}, 64'd0);
  endtask

  int r0, s0, a0;
  logic [26:0] got;

  initial begin
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_we    = 1'b0;
    bus.i_cmd_adr   = '0;
    bus.i_cmd_dat   = '0;
    bus.i_cmd_sel   = '0;
    bus.wb_dat_i    = '0;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_cyc",   {63'd0, bus.wb_cyc_o},    64'd0);
    chk("rst_stb",   {63'd0, bus.wb_stb_o},    64'd0);
    chk("rst_we",    {63'd0, bus.wb_we_o},     64'd0);
    chk("rst_ready", {63'd0, bus.o_cmd_ready}, 64'd1);
    chk("rst_busy",  {63'd0, bus.o_busy},      64'd0);
    chk("rst_rspv",  {63'd0, bus.o_rsp_valid}, 64'd0);
    chk("rst_rspd",  {32'd0, bus.o_rsp_data},  64'd0);
    reset = 1'b0;
    tick();

    // Single write; ack appears in the 2nd REQ cycle, seen at the 3rd edge -> cyc high 3 cycles
    slave_mode = 1;
    lat = 1;
    r0 = rsp_cnt;
    a0 = ack_cnt;
    push(1'b1, 27'h0001004, 32'hA5A5_0F0F, 4'hF);
    chk("wr_busy", {63'd0, bus.o_busy},   64'd1);
    chk("wr_cyc0", {63'd0, bus.wb_cyc_o}, 64'd0);
    tick();
    chk("wr_cyc",  {63'd0, bus.wb_cyc_o}, 64'd1);
    chk("wr_stb",  {63'd0, bus.wb_stb_o}, 64'd1);
    chk("wr_we",   {63'd0, bus.wb_we_o},  64'd1);
    chk("wr_sel",  {60'd0, bus.wb_sel_o}, 64'hF);
    chk("wr_adr",  {37'd0, bus.wb_adr_o}, 64'h0001004);
    chk("wr_dat",  {32'd0, bus.wb_dat_o}, 64'hA5A5_0F0F);
    wait_idle("wr_idle");
    chk("wr_len",  last_len, 3);
    chk("wr_norsp", rsp_cnt - r0, 0);
    chk("wr_acks", ack_cnt - a0, 1);
    chk("wr_we_after", {63'd0, bus.wb_we_o}, 64'd0);
    $display("txn write adr=0001004 len=%0d rsp=%0d", last_len, rsp_cnt - r0);

    // Single read returning DEADBEEF
    bus.wb_dat_i = 32'hDEAD_BEEF;
    r0 = rsp_cnt;
    push(1'b0, 27'h0002000, 32'h0, 4'hF);
    wait_idle("rd_idle");
    chk("rd_rspcnt", rsp_cnt - r0, 1);
    chk("rd_rspdat", {32'd0, last_rsp_data}, 64'hDEAD_BEEF);
    chk("rd_rsperr", {63'd0, last_rsp_err},  64'd0);
    chk("rd_hold",   {32'd0, bus.o_rsp_data}, 64'hDEAD_BEEF);
    chk("rd_pulse",  {63'd0, bus.o_rsp_valid}, 64'd0);
    $display("txn read adr=0002000 data=%08h err=%0d", last_rsp_data, last_rsp_err);

    // FIFO full with a stalled slave: the first command is already in flight when
    // the 4 entries fill, so ready drops after the 5th accept and the 6th is held.
    slave_mode = 0;
    lat = 0;
    s0 = stb_cnt;
    a0 = ack_cnt;
    iss_q.delete();
    for (int i = 0; i < 5; i++) push(1'b1, 27'h100 + 27'(i), 32'h1000 + 32'(i), 4'h3);
    chk("full_ready", {63'd0, bus.o_cmd_ready}, 64'd0);
    bus.i_cmd_we    = 1'b1;
    bus.i_cmd_adr   = 27'h105;
    bus.i_cmd_dat   = 32'h1005;
    bus.i_cmd_valid = 1'b1;
    tick();
    tick();
    tick();
    chk("full_held", {63'd0, bus.o_cmd_ready}, 64'd0);
    chk("full_one_issued", stb_cnt - s0, 1);
    slave_mode = 1;
    push(1'b1, 27'h105, 32'h1005, 4'h3);
    wait_idle("full_idle");
    chk("full_issued", stb_cnt - s0, 6);
    chk("full_acks", ack_cnt - a0, 6);
    for (int i = 0; i < 6; i++) begin
      got = (iss_q.size() != 0) ? iss_q.pop_front() : 27'h7FFFFFF;
      chk($sformatf("full_order%0d", i), {37'd0, got}, 64'h100 + 64'(i));
    end
    $display("txn full issued=%0d acks=%0d", stb_cnt - s0, ack_cnt - a0);

    // Half-rate slave: ack lingers one cycle after stb drops and must be ignored
    slave_mode = 2;
    s0 = stb_cnt;
    a0 = ack_cnt;
    r0 = rsp_cnt;
    min_gap = 1000;
    iss_q.delete();
    for (int i = 0; i < 4; i++) push(1'b1, 27'h200 + 27'(i), 32'h2000 + 32'(i), 4'hF);
    wait_idle("half_idle");
    chk("half_issued", stb_cnt - s0, 4);
    chk("half_acks", ack_cnt - a0, 4);
    chk("half_gap_ge2", {63'd0, min_gap >= 2}, 64'd1);
    chk("half_norsp", rsp_cnt - r0, 0);
    for (int i = 0; i < 4; i++) begin
      got = (iss_q.size() != 0) ? iss_q.pop_front() : 27'h7FFFFFF;
      chk($sformatf("half_order%0d", i), {37'd0, got}, 64'h200 + 64'(i));
    end
    $display("txn halfrate issued=%0d acks=%0d min_gap=%0d", stb_cnt - s0, ack_cnt - a0, min_gap);

    // Reset during REQ of a write, with a second command still queued
    slave_mode = 0;
    push(1'b1, 27'h400, 32'h4000, 4'hF);
    push(1'b1, 27'h404, 32'h4004, 4'hF);
    chk("rreq_cyc", {63'd0, bus.wb_cyc_o}, 64'd1);
    r0 = rsp_cnt;
    reset = 1'b1;
    #1;
    chk("rreq_cyc0",  {63'd0, bus.wb_cyc_o},    64'd0);
    chk("rreq_stb0",  {63'd0, bus.wb_stb_o},    64'd0);
    chk("rreq_ready", {63'd0, bus.o_cmd_ready}, 64'd1);
    chk("rreq_busy",  {63'd0, bus.o_busy},      64'd0);
    tick();
    reset = 1'b0;
    s0 = stb_cnt;
    for (int i = 0; i < 4; i++) tick();
    chk("rreq_flushed", stb_cnt - s0, 0);
    chk("rreq_idle",    {63'd0, bus.o_busy}, 64'd0);
    chk("rreq_norsp",   rsp_cnt - r0, 0);
    $display("txn reset_in_req cyc=%0d busy=%0d", bus.wb_cyc_o, bus.o_busy);

`ifdef GPU_WB_TIMEOUT_EN
    // Slave never acks the write; it times out after 16 REQ cycles, then the read issues
    slave_mode = 0;
    s0 = stb_cnt;
    r0 = rsp_cnt;
    bus.wb_dat_i = 32'h1234_5678;
    push(1'b1, 27'h300, 32'h3000, 4'hF);
    push(1'b0, 27'h304, 32'h0, 4'hF);
    for (int n = 0; n < 60 && rsp_cnt == r0; n++) tick();
    chk("tmo_rsp",  rsp_cnt - r0, 1);
    chk("tmo_len",  last_len, 16);
    chk("tmo_err",  {63'd0, last_rsp_err},  64'd1);
    chk("tmo_data", {32'd0, last_rsp_data}, 64'd0);
    slave_mode = 1;
    wait_idle("tmo_idle");
    chk("tmo_next_issued", stb_cnt - s0, 2);
    chk("tmo_next_rsp",  rsp_cnt - r0, 2);
    chk("tmo_next_err",  {63'd0, last_rsp_err},  64'd0);
    chk("tmo_next_data", {32'd0, last_rsp_data}, 64'h1234_5678);
    $display("txn timeout len=%0d then read data=%08h", last_len, last_rsp_data);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
